// File: rtl/cache_controller_pkg.sv
// Shared cache package.
// Holds the controller state encoding, the default line geometry, the
// opcode-independent memory constants and the packed control-output bundle
// that the controller drives each cycle.
package cache_controller_pkg;

    // Controller state encoding (2-bit, legacy-compatible constants)
    localparam logic [1:0] ST_IDLE       = 2'd0;
    localparam logic [1:0] ST_REFILL     = 2'd1;
    localparam logic [1:0] ST_WRITE_THRU = 2'd2;
    localparam logic [1:0] ST_RESUME     = 2'd3;

    // Line geometry and memory word constants
    localparam int DEFAULT_BLOCK_WORDS = 4;
    localparam int WORD_W              = 32;
    localparam int WORD_BYTES          = WORD_W / 8;

    // Single-bit control outputs, grouped so the next-state logic can
    // clear them all with one default assignment.
    typedef struct packed {
        logic stall;
        logic mem_req;
        logic mem_we;
        logic cache_we;
        logic cache_upd;
        logic valid_set;
    } ctl_t;

endpackage

// File: rtl/cache_controller_refill_counter.sv
// refill_counter: word index for a line refill.
// Ports:
//   clk, rst   - clock, synchronous active-high reset
//   clear      - synchronous clear (held while not refilling)
//   enable     - advance by one word (one memory ack)
//   cnt        - current word index
//   last       - cnt is on the final word of the line
// The line holds 2**CNT_W words, so the increment wraps to 0 by itself
// on the ack that completes the line.
module refill_counter #(
    parameter int CNT_W = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             enable,
    output logic [CNT_W-1:0] cnt,
    output logic             last
);

    always_ff @(posedge clk) begin
        if (rst || clear)
            cnt <= '0;
        else if (enable)
            cnt <= cnt + 1'b1;
    end

    assign last = &cnt;

endmodule

// File: rtl/cache_controller.sv
// cache_controller: blocking write-through / no-write-allocate controller.
// Ports:
//   clk, rst   - clock, synchronous active-high reset
//   mem_read   - load request from decoder
//   mem_write  - store request from decoder (wins over mem_read)
//   hit        - tag match and valid from the cache array
//   mem_ready  - main-memory per-word ack
//   stall      - freeze PC / pipeline registers (combinational)
//   mem_req    - main-memory access request
//   mem_we     - main-memory write enable
//   word_cnt   - refill word index (memory address + cache word select)
//   cache_we   - write refill word[word_cnt] into the line
//   cache_upd  - write store data into a hitting word
//   valid_set  - set valid and write the tag of the refilled line
module cache_controller
    import cache_controller_pkg::*;
#(
    parameter int BLOCK_WORDS = DEFAULT_BLOCK_WORDS,
    parameter int CNT_W       = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             mem_read,
    input  logic             mem_write,
    input  logic             hit,
    input  logic             mem_ready,
    output logic             stall,
    output logic             mem_req,
    output logic             mem_we,
    output logic [CNT_W-1:0] word_cnt,
    output logic             cache_we,
    output logic             cache_upd,
    output logic             valid_set
);

    logic [1:0] state, state_nxt;
    ctl_t       ctl;
    logic       cnt_en;
    logic       cnt_last;

    // Counter is held at zero outside REFILL, so every refill starts from
    // word 0 even after an abandoned one.
    refill_counter #(.CNT_W(CNT_W)) u_refill_counter (
        .clk    (clk),
        .rst    (rst),
        .clear  (state != ST_REFILL),
        .enable (cnt_en),
        .cnt    (word_cnt),
        .last   (cnt_last)
    );

    always_ff @(posedge clk) begin
        if (rst)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        ctl       = '0;
        cnt_en    = 1'b0;
        case (state)
            ST_IDLE: begin
                // A store takes priority; a hitting store also updates the
                // cache word now, a missing store leaves the cache alone.
                if (mem_write) begin
                    ctl.stall     = 1'b1;
                    ctl.cache_upd = hit;
                    state_nxt     = ST_WRITE_THRU;
                end else if (mem_read && !hit) begin
                    ctl.stall = 1'b1;
                    state_nxt = ST_REFILL;
                end
            end
            ST_REFILL: begin
                ctl.stall   = 1'b1;
                ctl.mem_req = 1'b1;
                if (mem_ready) begin
                    ctl.cache_we = 1'b1;
                    cnt_en       = 1'b1;
                    if (cnt_last) begin
                        ctl.valid_set = 1'b1;
                        state_nxt     = ST_RESUME;
                    end
                end
            end
            ST_WRITE_THRU: begin
                ctl.stall   = 1'b1;
                ctl.mem_req = 1'b1;
                ctl.mem_we  = 1'b1;
                if (mem_ready)
                    state_nxt = ST_RESUME;
            end
            default: begin
                // RESUME: one unstalled cycle so the held request retires.
                state_nxt = ST_IDLE;
            end
        endcase
    end

    assign stall     = ctl.stall;
    assign mem_req   = ctl.mem_req;
    assign mem_we    = ctl.mem_we;
    assign cache_we  = ctl.cache_we;
    assign cache_upd = ctl.cache_upd;
    assign valid_set = ctl.valid_set;

endmodule

// File: tb/tb_cache_controller.sv
// Directed bench for cache_controller (BLOCK_WORDS=4).
// Inputs change 1ns after the rising edge; outputs are compared at the
// falling edge. Outputs are packed as
// {stall, mem_req, mem_we, cache_we, cache_upd, valid_set, word_cnt[1:0]}.
module tb_cache_controller;

    logic       clk = 1'b0;
    logic       rst, mem_read, mem_write, hit, mem_ready;
    logic       stall, mem_req, mem_we, cache_we, cache_upd, valid_set;
    logic [1:0] word_cnt;
    int         checks = 0;
    int         failures = 0;

    always #5 clk = ~clk;

    cache_controller #(.BLOCK_WORDS(4), .CNT_W(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .mem_read  (mem_read),
        .mem_write (mem_write),
        .hit       (hit),
        .mem_ready (mem_ready),
        .stall     (stall),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .word_cnt  (word_cnt),
        .cache_we  (cache_we),
        .cache_upd (cache_upd),
        .valid_set (valid_set)
    );

    wire [7:0] obs = {stall, mem_req, mem_we, cache_we, cache_upd, valid_set, word_cnt};

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic r, input logic w, input logic h, input logic rdy);
        mem_read  = r;
        mem_write = w;
        hit       = h;
        mem_ready = rdy;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(0, 0, 0, 0);
        next_cycle();
        next_cycle();
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (obs !== 8'h00) begin
            failures++;
            $display("FAIL reset_outputs got=%h exp=%h", obs, 8'h00);
        end
        next_cycle();
    endtask

    task automatic test_read_hit();
        drive(1, 0, 1, 1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (obs !== 8'h00) begin
                failures++;
                $display("FAIL read_hit cyc=%0d got=%h exp=%h", i, obs, 8'h00);
            end
            next_cycle();
        end
        drive(0, 0, 0, 0);
    endtask

    // mem_ready held high, including in IDLE and RESUME where it is ignored.
    task automatic test_read_miss_stream();
        logic [7:0] exp [7] = '{8'h80, 8'hD0, 8'hD1, 8'hD2, 8'hD7, 8'h00, 8'h00};
        int stalls = 0;
        drive(1, 0, 0, 1);
        for (int i = 0; i < 7; i++) begin
            if (i >= 5) hit = 1'b1;  // line now valid
            @(negedge clk);
            checks++;
            if (obs !== exp[i]) begin
                failures++;
                $display("FAIL read_miss_stream cyc=%0d got=%h exp=%h", i, obs, exp[i]);
            end
            if (stall) stalls++;
            next_cycle();
        end
        checks++;
        if (stalls != 5) begin
            failures++;
            $display("FAIL read_miss_stream_stalls got=%0d exp=5", stalls);
        end
        drive(0, 0, 0, 0);
    endtask

    // Ack on every third refill cycle: 12 REFILL cycles + IDLE + RESUME.
    task automatic test_read_miss_slow();
        logic [7:0] e;
        logic [1:0] c;
        int stalls = 0;
        drive(1, 0, 0, 0);
        @(negedge clk);
        checks++;
        if (obs !== 8'h80) begin
            failures++;
            $display("FAIL read_miss_slow detect got=%h exp=%h", obs, 8'h80);
        end
        if (stall) stalls++;
        next_cycle();
        for (int j = 0; j < 12; j++) begin
            mem_ready = (j % 3 == 2);
            c = 2'(j / 3);
            e = {6'b110000, c};
            if (mem_ready) e[4] = 1'b1;
            if (mem_ready && c == 2'd3) e[2] = 1'b1;
            @(negedge clk);
            checks++;
            if (obs !== e) begin
                failures++;
                $display("FAIL read_miss_slow cyc=%0d got=%h exp=%h", j, obs, e);
            end
            if (stall) stalls++;
            next_cycle();
        end
        hit = 1'b1;
        mem_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (obs !== 8'h00) begin
            failures++;
            $display("FAIL read_miss_slow resume got=%h exp=%h", obs, 8'h00);
        end
        checks++;
        if (stalls != 13) begin
            failures++;
            $display("FAIL read_miss_slow_stalls got=%0d exp=13", stalls);
        end
        next_cycle();
        drive(0, 0, 0, 0);
    endtask

    // Write hit, ack after two wait cycles. Request held through RESUME.
    task automatic test_write_hit();
        logic [7:0] exp [5] = '{8'h88, 8'hE0, 8'hE0, 8'hE0, 8'h00};
        logic       rdy [5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        int stalls = 0;
        int wes = 0;
        drive(0, 1, 1, 0);
        for (int i = 0; i < 5; i++) begin
            mem_ready = rdy[i];
            @(negedge clk);
            checks++;
            if (obs !== exp[i]) begin
                failures++;
                $display("FAIL write_hit cyc=%0d got=%h exp=%h", i, obs, exp[i]);
            end
            if (stall) stalls++;
            if (mem_we) wes++;
            next_cycle();
        end
        checks++;
        if (stalls != 4 || wes != 3) begin
            failures++;
            $display("FAIL write_hit_latency got stall=%0d we=%0d exp stall=4 we=3", stalls, wes);
        end
        drive(0, 0, 0, 0);
    endtask

    // Write miss, plus read+write together (must take the write path).
    task automatic test_write_miss();
        logic [7:0] exp [3] = '{8'h80, 8'hE0, 8'h00};
        for (int t = 0; t < 2; t++) begin
            drive(t == 1, 1, 0, 1);
            for (int i = 0; i < 3; i++) begin
                @(negedge clk);
                checks++;
                if (obs !== exp[i]) begin
                    failures++;
                    $display("FAIL write_miss rw=%0d cyc=%0d got=%h exp=%h", t, i, obs, exp[i]);
                end
                next_cycle();
            end
            drive(0, 0, 0, 0);
            next_cycle();
        end
    endtask

    task automatic test_reset_mid_access();
        logic [7:0] exp [3] = '{8'h80, 8'hD0, 8'hD1};
        logic [7:0] exp2 [6] = '{8'h80, 8'hD0, 8'hD1, 8'hD2, 8'hD7, 8'h00};
        drive(1, 0, 0, 1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (obs !== exp[i]) begin
                failures++;
                $display("FAIL rst_refill pre cyc=%0d got=%h exp=%h", i, obs, exp[i]);
            end
            next_cycle();
        end
        rst = 1'b1;  // word_cnt=2, ack present
        @(negedge clk);
        checks++;
        if (obs !== 8'hD2) begin
            failures++;
            $display("FAIL rst_refill at_reset got=%h exp=%h", obs, 8'hD2);
        end
        next_cycle();
        rst = 1'b0;
        drive(0, 0, 0, 0);
        @(negedge clk);
        checks++;
        if (obs !== 8'h00) begin
            failures++;
            $display("FAIL rst_refill after got=%h exp=%h", obs, 8'h00);
        end
        next_cycle();
        drive(1, 0, 0, 1);
        for (int i = 0; i < 6; i++) begin
            if (i == 5) hit = 1'b1;
            @(negedge clk);
            checks++;
            if (obs !== exp2[i]) begin
                failures++;
                $display("FAIL rst_refill retry cyc=%0d got=%h exp=%h", i, obs, exp2[i]);
            end
            next_cycle();
        end
        // Reset in the middle of a write-through.
        drive(0, 1, 0, 0);
        next_cycle();
        @(negedge clk);
        checks++;
        if (obs !== 8'hE0) begin
            failures++;
            $display("FAIL rst_write pre got=%h exp=%h", obs, 8'hE0);
        end
        rst = 1'b1;
        next_cycle();
        rst = 1'b0;
        drive(0, 0, 0, 0);
        @(negedge clk);
        checks++;
        if (obs !== 8'h00) begin
            failures++;
            $display("FAIL rst_write after got=%h exp=%h", obs, 8'h00);
        end
        next_cycle();
    endtask

    // RESUME of a refill followed directly by a store hit in IDLE.
    task automatic test_back_to_back();
        drive(1, 0, 0, 1);
        repeat (5) next_cycle();
        @(negedge clk);
        checks++;
        if (obs !== 8'h00) begin
            failures++;
            $display("FAIL back_to_back resume got=%h exp=%h", obs, 8'h00);
        end
        next_cycle();
        drive(0, 1, 1, 0);
        @(negedge clk);
        checks++;
        if (obs !== 8'h88) begin
            failures++;
            $display("FAIL back_to_back store got=%h exp=%h", obs, 8'h88);
        end
        next_cycle();
        mem_ready = 1'b1;
        next_cycle();
        drive(0, 0, 0, 0);
        next_cycle();
    endtask

    initial begin
        test_reset();
        test_read_hit();
        test_read_miss_stream();
        test_read_miss_slow();
        test_write_hit();
        test_write_miss();
        test_reset_mid_access();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
